// File: rtl/fetch_stage_pkg.sv
// Shared pipeline definitions for the fetch stage: FSM states, IF/ID layout and bubble word.
package fetch_stage_pkg;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned JUMP_IDX = 26;

    localparam logic [XLEN-1:0] NopWord = 32'h0000_0000;

    typedef enum logic [1:0] {
        StBoot,
        StRun,
        StHalt
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc4;
        logic            valid;
    } ifid_t;

    // j target: upper nibble of the delay-slot PC, word index shifted into place.
    function automatic logic [XLEN-1:0] jump_target(input logic [3:0]          pc4_hi,
                                                    input logic [JUMP_IDX-1:0] index);
        return {pc4_hi, index, 2'b00};
    endfunction

endpackage

// File: rtl/fetch_stage_next_pc_sel.sv
// Next-PC priority mux for the fetch stage: branch, jump, stall, halt, sequential.
module fetch_stage_next_pc_sel
    import fetch_stage_pkg::*;
(
    input  fetch_state_e             state_i,
    input  logic [XLEN-1:0]          pc_i,
    input  logic                     at_limit_i,
    input  logic                     stall_i,
    input  logic                     id_jump_i,
    input  logic [JUMP_IDX-1:0]      id_jump_index_i,
    input  logic [3:0]               ifid_pc4_hi_i,
    input  logic                     ex_branch_taken_i,
    input  logic [XLEN-1:0]          ex_branch_target_i,
    output logic [XLEN-1:0]          next_pc_o,
    output logic                     flush_o,
    output logic                     fetch_o
);

    always_comb begin
        next_pc_o = pc_i;
        flush_o   = 1'b0;
        fetch_o   = 1'b0;
        unique case (state_i)
            StBoot: begin
                flush_o = 1'b1;
            end
            StRun: begin
                if (ex_branch_taken_i) begin
                    next_pc_o = ex_branch_target_i;
                    flush_o   = 1'b1;
                end else if (id_jump_i && !stall_i) begin
                    next_pc_o = jump_target(ifid_pc4_hi_i, id_jump_index_i);
                    flush_o   = 1'b1;
                end else if (at_limit_i) begin
                    // Past the program: stop fetching regardless of stall.
                    flush_o = 1'b1;
                end else if (!stall_i) begin
                    next_pc_o = pc_i + 32'd4;
                    fetch_o   = 1'b1;
                end
            end
            StHalt: begin
                flush_o = 1'b1;
                if (ex_branch_taken_i) begin
                    next_pc_o = ex_branch_target_i;
                end
            end
            default: begin
                flush_o = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/fetch_stage.sv
// IF stage: PC register, boot/run/halt FSM, IF/ID pipeline register and fetch counter.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_LIMIT = 32'd28,
    parameter logic [31:0] NOP_WORD = NopWord
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_i,
    input  logic        id_jump_i,
    input  logic [25:0] id_jump_index_i,
    input  logic        ex_branch_taken_i,
    input  logic [31:0] ex_branch_target_i,
    input  logic [31:0] imem_instr_i,
    output logic [31:0] imem_pc_o,
    output logic [31:0] ifid_instr_o,
    output logic [31:0] ifid_pc4_o,
    output logic        ifid_valid_o,
    output logic        halted_o,
    output logic [31:0] fetch_count_o
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    ifid_t        ifid_q, ifid_d;
    logic [31:0]  count_q, count_d;

    logic flush, fetch, at_limit;

    assign at_limit = (pc_q >= PC_LIMIT);

    fetch_stage_next_pc_sel u_next_pc_sel (
        .state_i            (state_q),
        .pc_i               (pc_q),
        .at_limit_i         (at_limit),
        .stall_i            (stall_i),
        .id_jump_i          (id_jump_i),
        .id_jump_index_i    (id_jump_index_i),
        .ifid_pc4_hi_i      (ifid_q.pc4[31:28]),
        .ex_branch_taken_i  (ex_branch_taken_i),
        .ex_branch_target_i (ex_branch_target_i),
        .next_pc_o          (pc_d),
        .flush_o            (flush),
        .fetch_o            (fetch)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StBoot: state_d = StRun;
            StRun: begin
                if (!ex_branch_taken_i && !(id_jump_i && !stall_i) && at_limit) begin
                    state_d = StHalt;
                end
            end
            StHalt: begin
                if (ex_branch_taken_i) begin
                    state_d = StRun;
                end
            end
            default: state_d = StBoot;
        endcase
    end

    always_comb begin
        ifid_d = ifid_q;
        if (flush) begin
            ifid_d = '{instr: NOP_WORD, pc4: 32'd0, valid: 1'b0};
        end else if (fetch) begin
            // On a sequential fetch the next PC is exactly this instruction's PC+4.
            ifid_d = '{instr: imem_instr_i, pc4: pc_d, valid: 1'b1};
        end
    end

    always_comb begin
        count_d = count_q;
        if (fetch && (count_q != 32'hFFFF_FFFF)) begin
            count_d = count_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= StBoot;
            pc_q    <= RESET_PC;
            ifid_q  <= '{instr: NOP_WORD, pc4: 32'd0, valid: 1'b0};
            count_q <= 32'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ifid_q  <= ifid_d;
            count_q <= count_d;
        end
    end

    assign imem_pc_o     = pc_q;
    assign ifid_instr_o  = ifid_q.instr;
    assign ifid_pc4_o    = ifid_q.pc4;
    assign ifid_valid_o  = ifid_q.valid;
    assign halted_o      = (state_q == StHalt);
    assign fetch_count_o = count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage against the stock 7-instruction image.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall_i;
    logic        id_jump_i;
    logic [25:0] id_jump_index_i;
    logic        ex_branch_taken_i;
    logic [31:0] ex_branch_target_i;
    logic [31:0] imem_instr_i;
    logic [31:0] imem_pc_o;
    logic [31:0] ifid_instr_o;
    logic [31:0] ifid_pc4_o;
    logic        ifid_valid_o;
    logic        halted_o;
    logic [31:0] fetch_count_o;

    logic        jump_force;
    logic [25:0] jump_force_idx;
    logic [31:0] rom [0:7];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk                (clk),
        .reset              (reset),
        .stall_i            (stall_i),
        .id_jump_i          (id_jump_i),
        .id_jump_index_i    (id_jump_index_i),
        .ex_branch_taken_i  (ex_branch_taken_i),
        .ex_branch_target_i (ex_branch_target_i),
        .imem_instr_i       (imem_instr_i),
        .imem_pc_o          (imem_pc_o),
        .ifid_instr_o       (ifid_instr_o),
        .ifid_pc4_o         (ifid_pc4_o),
        .ifid_valid_o       (ifid_valid_o),
        .halted_o           (halted_o),
        .fetch_count_o      (fetch_count_o)
    );

    // Instruction memory and a minimal ID decoder for j.
    assign imem_instr_i    = (imem_pc_o < 32'd32) ? rom[imem_pc_o[4:2]] : 32'h0;
    assign id_jump_i       = jump_force | (ifid_valid_o && ifid_instr_o[31:26] == 6'h02);
    assign id_jump_index_i = jump_force ? jump_force_idx : ifid_instr_o[25:0];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_fetch(input string tag, input logic [31:0] instr, input logic [31:0] pc,
                             input logic [31:0] cnt);
        check_eq({tag, ".instr"}, ifid_instr_o, instr);
        check_eq({tag, ".valid"}, {31'd0, ifid_valid_o}, 32'd1);
        check_eq({tag, ".pc4"}, ifid_pc4_o, pc);
        check_eq({tag, ".pc"}, imem_pc_o, pc);
        check_eq({tag, ".cnt"}, fetch_count_o, cnt);
    endtask

    task automatic chk_bubble(input string tag, input logic [31:0] pc, input logic halted);
        check_eq({tag, ".pc"}, imem_pc_o, pc);
        check_eq({tag, ".valid"}, {31'd0, ifid_valid_o}, 32'd0);
        check_eq({tag, ".instr"}, ifid_instr_o, 32'h0);
        check_eq({tag, ".halted"}, {31'd0, halted_o}, {31'd0, halted});
    endtask

    initial begin
        rom[0] = 32'h8C010000; rom[1] = 32'h8C020001; rom[2] = 32'h00220818;
        rom[3] = 32'h08000005; rom[4] = 32'h00221018; rom[5] = 32'h04260003;
        rom[6] = 32'hAC060004; rom[7] = 32'h00000000;
        reset = 1'b0; stall_i = 1'b0; ex_branch_taken_i = 1'b0; ex_branch_target_i = 32'h0;
        jump_force = 1'b0; jump_force_idx = 26'h0;

        // Reset and boot
        repeat (3) step();
        chk_bubble("rst", 32'd0, 1'b0);
        check_eq("rst.cnt", fetch_count_o, 32'd0);
        check_eq("rst.pc4", ifid_pc4_o, 32'd0);
        reset = 1'b1;
        step(); chk_bubble("boot", 32'd0, 1'b0);
        step(); chk_fetch("f0", 32'h8C010000, 32'd4, 32'd1);
        step(); chk_fetch("f1", 32'h8C020001, 32'd8, 32'd2);

        // Stall two cycles at pc=8
        stall_i = 1'b1;
        step(); chk_fetch("st1", 32'h8C020001, 32'd8, 32'd2);
        step(); chk_fetch("st2", 32'h8C020001, 32'd8, 32'd2);
        stall_i = 1'b0;
        step(); chk_fetch("f2", 32'h00220818, 32'd12, 32'd3);
        step(); chk_fetch("f3", 32'h08000005, 32'd16, 32'd4);

        // j 5 in ID redirects to 20; 00221018 squashed
        step(); chk_bubble("jmp", 32'd20, 1'b0);
        check_eq("jmp.cnt", fetch_count_o, 32'd4);
        step(); chk_fetch("f5", 32'h04260003, 32'd24, 32'd5);
        step(); chk_fetch("f6", 32'hAC060004, 32'd28, 32'd6);

        // Halt at PC_LIMIT
        step(); chk_bubble("halt1", 32'd28, 1'b1);
        step(); chk_bubble("halt2", 32'd28, 1'b1);
        check_eq("halt.cnt", fetch_count_o, 32'd6);

        // Branch out of halt to 0
        ex_branch_taken_i = 1'b1; ex_branch_target_i = 32'd0;
        step(); chk_bubble("bra0", 32'd0, 1'b0);
        ex_branch_taken_i = 1'b0;
        step(); chk_fetch("rf0", 32'h8C010000, 32'd4, 32'd7);

        // Branch beats simultaneous jump and stall
        ex_branch_taken_i = 1'b1; ex_branch_target_i = 32'd16;
        stall_i = 1'b1; jump_force = 1'b1; jump_force_idx = 26'd3;
        step(); chk_bubble("bra16", 32'd16, 1'b0);
        check_eq("bra16.cnt", fetch_count_o, 32'd7);
        ex_branch_taken_i = 1'b0; stall_i = 1'b0; jump_force = 1'b0;
        step(); chk_fetch("f4", 32'h00221018, 32'd20, 32'd8);
        step(); chk_fetch("f5b", 32'h04260003, 32'd24, 32'd9);
        step(); chk_fetch("f6b", 32'hAC060004, 32'd28, 32'd10);
        step(); chk_bubble("halt3", 32'd28, 1'b1);

        // Reset while halted
        reset = 1'b0;
        step(); chk_bubble("rst2", 32'd0, 1'b0);
        check_eq("rst2.cnt", fetch_count_o, 32'd0);
        reset = 1'b1;
        step(); chk_bubble("boot2", 32'd0, 1'b0);
        step(); chk_fetch("rf1", 32'h8C010000, 32'd4, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
